instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory request/response channel and
// the decode-side output channel of the instruction fetch stage.
//   imem_req_valid/ready/addr : fetch request handshake and byte address
//   imem_rsp_valid/data       : in-order response with the instruction word
//   out_valid/ready/instr/pc  : instruction handed to decode with its PC
// master = fetch stage, slave = memory plus decode side.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited instruction fetch stage.
// Issues sequential fetch requests, tags each accepted request with its PC in
// an in-order queue, buffers returning instructions in a small FIFO and hands
// them to decode. A redirect flushes the FIFO, restarts fetch at the new
// (word-aligned) target and drops the responses of requests still in flight.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   bus         : instr_fetch_if.master (imem request/response, decode output)
//   redirect    : PC override from execute / PC select
//   redirect_pc : new fetch target
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_if.master        bus,
  input  logic                 redirect,
  input  logic [63:0]          redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [63:0]   pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] discard_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] tag_wr_r;
  logic [PW-1:0] tag_rd_r;
  logic [PW-1:0] fifo_wr_r;
  logic [PW-1:0] fifo_rd_r;
  logic [63:0]   tag_pc_r     [DEPTH];
  logic [31:0]   fifo_instr_r [DEPTH];
  logic [63:0]   fifo_pc_r    [DEPTH];

  logic [CW:0]   credit_used_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_ok_s;
  logic          rsp_drop_s;
  logic          push_s;
  logic          pop_s;
  logic [63:0]   pc_nxt_s;
  logic [CW-1:0] inflight_nxt_s;
  logic [CW-1:0] discard_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [PW-1:0] fifo_wr_nxt_s;
  logic [PW-1:0] fifo_rd_nxt_s;
  logic          unused_pc_bits_s;

  // Circular pointer increment for a DEPTH-entry ring (DEPTH need not be 2^n).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // The low target bits are forced to zero, so they are intentionally unused.
  assign unused_pc_bits_s = ^redirect_pc[1:0];

  // Handshake qualifiers. Credits come only from registered counts, so
  // neither out_ready nor imem_rsp_valid reaches imem_req_valid/out_valid.
  // Gating with reset keeps the request low while reset is held.
  always_comb begin
    credit_used_s = {1'b0, inflight_r} + {1'b0, count_r};
    req_valid_s   = reset & ~redirect & (credit_used_s < DEPTH_C);
    req_fire_s    = req_valid_s & bus.imem_req_ready;
    // A response with nothing in flight is a protocol error and is ignored.
    rsp_ok_s      = bus.imem_rsp_valid & (inflight_r != {CW{1'b0}});
    rsp_drop_s    = rsp_ok_s & (discard_r != {CW{1'b0}});
    push_s        = rsp_ok_s & ~rsp_drop_s & ~redirect;
    pop_s         = (count_r != {CW{1'b0}}) & bus.out_ready & ~redirect;
  end

  // Next-state for PC, counters and FIFO pointers; redirect wins over all.
  always_comb begin
    inflight_nxt_s = inflight_r + CW'(req_fire_s) - CW'(rsp_ok_s);
    pc_nxt_s       = pc_r;
    discard_nxt_s  = discard_r;
    count_nxt_s    = count_r;
    fifo_wr_nxt_s  = fifo_wr_r;
    fifo_rd_nxt_s  = fifo_rd_r;
    if (redirect) begin
      pc_nxt_s      = {redirect_pc[63:2], 2'b00};
      count_nxt_s   = {CW{1'b0}};
      fifo_wr_nxt_s = {PW{1'b0}};
      fifo_rd_nxt_s = {PW{1'b0}};
      // Everything still outstanding after this edge belongs to the old path.
      discard_nxt_s = inflight_nxt_s;
    end else begin
      if (req_fire_s) begin
        pc_nxt_s = pc_r + 64'd4;
      end else begin
        pc_nxt_s = pc_r;
      end
      if (push_s) begin
        fifo_wr_nxt_s = ptr_inc(fifo_wr_r);
      end else begin
        fifo_wr_nxt_s = fifo_wr_r;
      end
      if (pop_s) begin
        fifo_rd_nxt_s = ptr_inc(fifo_rd_r);
      end else begin
        fifo_rd_nxt_s = fifo_rd_r;
      end
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      if (rsp_drop_s) begin
        discard_nxt_s = discard_r - CW'(1);
      end else begin
        discard_nxt_s = discard_r;
      end
    end
  end

  // State registers, PC tag queue and instruction buffer storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      discard_r  <= {CW{1'b0}};
      count_r    <= {CW{1'b0}};
      tag_wr_r   <= {PW{1'b0}};
      tag_rd_r   <= {PW{1'b0}};
      fifo_wr_r  <= {PW{1'b0}};
      fifo_rd_r  <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_pc_r[i]     <= 64'd0;
        fifo_instr_r[i] <= 32'd0;
        fifo_pc_r[i]    <= 64'd0;
      end
    end else begin
      pc_r       <= pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      discard_r  <= discard_nxt_s;
      count_r    <= count_nxt_s;
      fifo_wr_r  <= fifo_wr_nxt_s;
      fifo_rd_r  <= fifo_rd_nxt_s;
      if (req_fire_s) begin
        tag_pc_r[tag_wr_r] <= pc_r;
        tag_wr_r           <= ptr_inc(tag_wr_r);
      end
      // Every valid response retires its tag, dropped or not.
      if (rsp_ok_s) begin
        tag_rd_r <= ptr_inc(tag_rd_r);
      end
      if (push_s) begin
        fifo_instr_r[fifo_wr_r] <= bus.imem_rsp_data;
        fifo_pc_r[fifo_wr_r]    <= tag_pc_r[tag_rd_r];
      end
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_r;
  assign bus.out_valid      = (count_r != {CW{1'b0}});
  assign bus.out_instr      = fifo_instr_r[fifo_rd_r];
  assign bus.out_pc         = fifo_pc_r[fifo_rd_r];

endmodule
